huffman_dec_controller: RTL and testbench
=========================================

# huffman_dec_controller

Sequences JPEG baseline Huffman decoding of one 8x8 block: it consumes a serial entropy-coded bitstream, resolves DC/AC codewords through an external table-lookup block, and rebuilds the 64 zigzag-ordered 10-bit coefficients. It is the inverse of the Huffman encode controller. Its 640-bit output uses the same packing the encoder consumes, so a decoded block can be fed back to the encoder unchanged. It keeps the DC predictor across blocks of one component.

## Interface
- No parameters.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- is_luminance  in  1  table class for the current block; sampled on start and forwarded as lut_luma.
- Huffman_dec_start  in  1  one-cycle pulse; starts a block. Accepted only in IDLE.
- dc_pred_clear  in  1  clears the DC predictor to 0 (component change or restart). Ignored while active.
- bit_in  in  1  next stream bit, MSB-first.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  controller takes bit_in this cycle; a bit transfers when bit_valid && bit_ready.
- lut_code  out  16  accumulated codeword, right-aligned.
- lut_len  out  5  number of valid bits in lut_code (0..16).
- lut_is_dc  out  1  1 = query the DC table, 0 = query the AC table.
- lut_luma  out  1  latched is_luminance.
- lut_hit  in  1  combinational: {lut_code, lut_len} is a complete codeword.
- lut_symbol  in  8  DC: size in [3:0]. AC: run in [7:4], size in [3:0].
- zigzag_pix_out  out  640  coefficient k sits in [639-10k -: 10]; DC is [639:630].
- block_valid  out  1  one-cycle pulse; zigzag_pix_out holds a complete block.
- Huffmandec_active  out  1  high from start acceptance until DONE or ERR.
- dec_error  out  1  sticky error flag; cleared by reset or the next accepted start.

## Operation
- States: IDLE, DC_CODE, DC_BITS, AC_CODE, AC_BITS, DONE, ERR.
- IDLE, on start:
  - Clear zigzag_pix_out, code accumulator and len; set pos=1; clear dec_error.
  - Latch is_luminance; go to DC_CODE.
- *_CODE states:
  - bit_ready = (lut_len==0 || !lut_hit).
  - Each accepted bit updates lut_code <= {lut_code[14:0], bit_in} and lut_len <= lut_len+1.
  - When lut_len!=0 && lut_hit: latch size and run, clear the accumulator, take no bit that cycle.
  - lut_len==16 && !lut_hit -> ERR.
- DC symbol:
  - size>10 -> ERR.
  - size==0: diff=0; write the DC in the hit cycle and go to AC_CODE.
  - Otherwise go to DC_BITS.
- *_BITS states:
  - bit_ready=1; accept exactly `size` bits MSB-first into v.
  - Decoded value = v if v[size-1]==1, else v-(2^size-1).
  - Sign-extend the value to 10 bits.
- DC write:
  - coef0 = (pred + diff) mod 2^10 (two's complement, wraps).
  - pred <= coef0.
  - Then go to AC_CODE.
- AC symbols:
  - 0x00 (EOB): go to DONE; remaining coefficients stay 0.
  - 0xF0 (ZRL): pos += 16. If the new pos > 63 -> ERR, else stay in AC_CODE.
  - size==0 with any other run: ERR.
  - size>10: ERR.
  - Otherwise: if pos+run > 63 -> ERR. Else go to AC_BITS, then write coefficient (pos+run) and set pos <= pos+run+1.
  - If the new pos == 64 -> DONE (no EOB expected); else back to AC_CODE.
- DONE: block_valid=1 for one cycle; Huffmandec_active <= 0; go to IDLE.
- ERR: dec_error <= 1; Huffmandec_active <= 0; go to IDLE. The predictor is not updated by a failed DC.
- dc_pred_clear in IDLE sets pred=0. If it coincides with a start, the clear applies first.
- Huffman_dec_start outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE; pred=0.
  - Outputs all 0: zigzag_pix_out, lut_code, lut_len, lut_is_dc, lut_luma, bit_ready, block_valid, Huffmandec_active, dec_error.
- Start at edge N: Huffmandec_active=1 and bit_ready=1 from cycle N+1.
- At most one stream bit per cycle.
- Each codeword costs its bit count plus one lookup cycle (bit_ready low in the hit cycle).
- Each magnitude field costs `size` cycles.
- A coefficient is registered at the edge that accepts its last magnitude bit.
- block_valid asserts the cycle after the EOB hit cycle, or the cycle after the coefficient-63 write.
- bit_valid low stalls the state machine with no state change.
- Reset mid-block: everything returns to reset values next cycle, pred included; no block_valid is produced.

## Test plan
- Pred 0, luma, stream 100 101 1010 (DC size 3, value 5, EOB) -> coef0=5, others 0, block_valid 12 cycles after start acceptance.
- Follow-on luma block, stream 011 01 1010 -> diff -2, coef0=3, pred=3.
- dc_pred_clear, then stream 00 then 1010 -> coef0=0, other coefficients 0.
- AC run/size 0x21, bits "0" (value -1), then EOB -> coef3=0x3FF, coef1=coef2=0. Repeat with bit_valid deasserted 3 cycles mid-codeword -> same result, completion 3 cycles later.
- Lookup model never hits for 16 bits -> dec_error=1, Huffmandec_active=0, no block_valid. Next start clears dec_error.
- Four ZRL symbols from pos=1 -> ERR on the fourth (pos 65). Also: reset asserted mid AC_BITS -> all outputs return to their reset values (all 0) next cycle.

Source files
------------

// File: rtl/huffman_dec_controller_if.sv
// Bit-stream, table-lookup and block-output signals of the Huffman decode controller.
// The slave modport is the controller side; the master modport is the environment side.
interface huffman_dec_controller_if;
  localparam int unsigned CODE_W = 16;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned SYM_W  = 8;
  localparam int unsigned BLK_W  = 640;

  logic              is_luminance;
  logic              Huffman_dec_start;
  logic              dc_pred_clear;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [CODE_W-1:0] lut_code;
  logic [LEN_W-1:0]  lut_len;
  logic              lut_is_dc;
  logic              lut_luma;
  logic              lut_hit;
  logic [SYM_W-1:0]  lut_symbol;
  logic [BLK_W-1:0]  zigzag_pix_out;
  logic              block_valid;
  logic              Huffmandec_active;
  logic              dec_error;

  modport slave (
    input  is_luminance, Huffman_dec_start, dc_pred_clear, bit_in, bit_valid,
           lut_hit, lut_symbol,
    output bit_ready, lut_code, lut_len, lut_is_dc, lut_luma,
           zigzag_pix_out, block_valid, Huffmandec_active, dec_error
  );

  modport master (
    output is_luminance, Huffman_dec_start, dc_pred_clear, bit_in, bit_valid,
           lut_hit, lut_symbol,
    input  bit_ready, lut_code, lut_len, lut_is_dc, lut_luma,
           zigzag_pix_out, block_valid, Huffmandec_active, dec_error
  );
endinterface

// File: rtl/huffman_dec_controller.sv
// JPEG baseline Huffman decode sequencer for one 8x8 block: serial bits in, codewords
// resolved by an external lookup, 64 zigzag-ordered 10-bit coefficients out.
module huffman_dec_controller (
  input  logic                    clock,
  input  logic                    reset,
  huffman_dec_controller_if.slave bus
);
  localparam int unsigned COEF_W = 10;
  localparam int unsigned BLK_W  = 640;
  localparam int unsigned POS_W  = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_DC_CODE, S_DC_BITS, S_AC_CODE, S_AC_BITS, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_state;
  logic [BLK_W-1:0]    r_zz, w_zz;
  logic [15:0]         r_code, w_code;
  logic [4:0]          r_len, w_len;
  logic [COEF_W-1:0]   r_pred, w_pred;
  logic [POS_W-1:0]    r_pos, w_pos;
  logic [3:0]          r_run, w_run, r_size, w_size, r_cnt, w_cnt;
  logic [COEF_W-2:0]   r_mag, w_mag;
  logic                r_luma, w_luma, r_error, w_error;
  logic                r_is_dc, w_is_dc, r_block_valid, w_block_valid, r_active, w_active;

  logic                w_in_code, w_in_bits, w_bit_ready, w_take, w_hit, w_last, w_sign;
  logic [3:0]          w_sym_size, w_sym_run;
  logic [COEF_W-1:0]   w_v, w_mask, w_top, w_val, w_dc_sum;
  logic [POS_W-1:0]    w_idx, w_hit_idx, w_zrl_pos;
  logic [9:0]          w_base;

  assign w_in_code   = (r_state == S_DC_CODE) || (r_state == S_AC_CODE);
  assign w_in_bits   = (r_state == S_DC_BITS) || (r_state == S_AC_BITS);
  assign w_bit_ready = w_in_code ? ((r_len == 5'd0) || !bus.lut_hit) : w_in_bits;
  assign w_take      = w_bit_ready && bus.bit_valid;
  assign w_hit       = (r_len != 5'd0) && bus.lut_hit;
  assign w_sym_size  = bus.lut_symbol[3:0];
  assign w_sym_run   = bus.lut_symbol[7:4];

  // Magnitude field: leading 0 means negative, offset by 2^size-1 (wraps mod 2^10)
  assign w_v      = {r_mag, bus.bit_in};
  assign w_mask   = COEF_W'((11'd1 << r_size) - 11'd1);
  assign w_top    = COEF_W'((11'd1 << r_size) >> 1);
  assign w_sign   = |(w_v & w_top);
  assign w_val    = w_sign ? w_v : (w_v - w_mask);
  assign w_last   = (r_cnt == (r_size - 4'd1));
  assign w_dc_sum = r_pred + w_val;

  assign w_idx     = r_pos + POS_W'(r_run);
  assign w_hit_idx = r_pos + POS_W'(w_sym_run);
  assign w_zrl_pos = r_pos + 7'd16;
  assign w_base    = 10'd639 - (10'(w_idx[5:0]) * 10'd10);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_zz          <= '0;
      r_code        <= '0;
      r_len         <= '0;
      r_pred        <= '0;
      r_pos         <= '0;
      r_run         <= '0;
      r_size        <= '0;
      r_cnt         <= '0;
      r_mag         <= '0;
      r_luma        <= 1'b0;
      r_error       <= 1'b0;
      r_is_dc       <= 1'b0;
      r_block_valid <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_zz          <= w_zz;
      r_code        <= w_code;
      r_len         <= w_len;
      r_pred        <= w_pred;
      r_pos         <= w_pos;
      r_run         <= w_run;
      r_size        <= w_size;
      r_cnt         <= w_cnt;
      r_mag         <= w_mag;
      r_luma        <= w_luma;
      r_error       <= w_error;
      r_is_dc       <= w_is_dc;
      r_block_valid <= w_block_valid;
      r_active      <= w_active;
    end
  end

  always_comb begin
    w_state = r_state;
    w_zz    = r_zz;
    w_code  = r_code;
    w_len   = r_len;
    w_pred  = r_pred;
    w_pos   = r_pos;
    w_run   = r_run;
    w_size  = r_size;
    w_cnt   = r_cnt;
    w_mag   = r_mag;
    w_luma  = r_luma;
    w_error = r_error;

    case (r_state)
      S_IDLE: begin
        if (bus.dc_pred_clear) w_pred = '0;
        if (bus.Huffman_dec_start) begin
          w_zz    = '0;
          w_code  = '0;
          w_len   = '0;
          w_pos   = 7'd1;
          w_error = 1'b0;
          w_luma  = bus.is_luminance;
          w_state = S_DC_CODE;
        end
      end
      S_DC_CODE, S_AC_CODE: begin
        if (w_hit) begin
          w_code = '0;
          w_len  = '0;
          w_size = w_sym_size;
          w_run  = w_sym_run;
          w_cnt  = '0;
          w_mag  = '0;
          if (r_state == S_DC_CODE) begin
            if (w_sym_size > 4'd10) begin
              w_state = S_ERR;
            end else if (w_sym_size == 4'd0) begin
              w_zz[639 -: 10] = r_pred;
              w_state         = S_AC_CODE;
            end else begin
              w_state = S_DC_BITS;
            end
          end else if (bus.lut_symbol == 8'h00) begin
            w_state = S_DONE;
          end else if (bus.lut_symbol == 8'hF0) begin
            w_pos = w_zrl_pos;
            if (w_zrl_pos > 7'd63) w_state = S_ERR;
          end else if ((w_sym_size == 4'd0) || (w_sym_size > 4'd10) || (w_hit_idx > 7'd63)) begin
            w_state = S_ERR;
          end else begin
            w_state = S_AC_BITS;
          end
        end else if (r_len == 5'd16) begin
          w_state = S_ERR;
        end else if (w_take) begin
          w_code = {r_code[14:0], bus.bit_in};
          w_len  = r_len + 5'd1;
        end
      end
      S_DC_BITS, S_AC_BITS: begin
        if (w_take) begin
          w_mag = w_v[8:0];
          w_cnt = r_cnt + 4'd1;
          if (w_last) begin
            if (r_state == S_DC_BITS) begin
              w_zz[639 -: 10] = w_dc_sum;
              w_pred          = w_dc_sum;
              w_state         = S_AC_CODE;
            end else begin
              w_zz[w_base -: 10] = w_val;
              w_pos              = w_idx + 7'd1;
              w_state            = (w_idx == 7'd63) ? S_DONE : S_AC_CODE;
            end
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Status outputs are registered from the state being entered
    w_active      = (w_state == S_DC_CODE) || (w_state == S_DC_BITS) ||
                    (w_state == S_AC_CODE) || (w_state == S_AC_BITS);
    w_is_dc       = (w_state == S_DC_CODE) || (w_state == S_DC_BITS);
    w_block_valid = (w_state == S_DONE);
    if (w_state == S_ERR) w_error = 1'b1;
  end

  assign bus.bit_ready         = w_bit_ready;
  assign bus.lut_code          = r_code;
  assign bus.lut_len           = r_len;
  assign bus.lut_is_dc         = r_is_dc;
  assign bus.lut_luma          = r_luma;
  assign bus.zigzag_pix_out    = r_zz;
  assign bus.block_valid       = r_block_valid;
  assign bus.Huffmandec_active = r_active;
  assign bus.dec_error         = r_error;
endmodule

// File: tb/tb_huffman_dec_controller.sv
// Scoreboard bench for huffman_dec_controller: streams of '0'/'1' bits ('s' = one idle
// cycle) against a small lookup table; expected blocks and latencies are queued at start.
module tb_huffman_dec_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  huffman_dec_controller_if bus ();

  huffman_dec_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [639:0] zz;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   bit_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   bv_cnt = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   took = 1'b0;
  bit   lut_never = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Lookup table model: small DC/AC code sets, or a table that never matches
  always_comb begin
    bus.lut_hit    = 1'b0;
    bus.lut_symbol = 8'h00;
    if (!lut_never) begin
      case ({bus.lut_is_dc, bus.lut_len, bus.lut_code})
        {1'b1, 5'd2,  16'b00}:          begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'h00; end
        {1'b1, 5'd3,  16'b011}:         begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'h02; end
        {1'b1, 5'd3,  16'b100}:         begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'h03; end
        {1'b0, 5'd2,  16'b00}:          begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'h01; end
        {1'b0, 5'd4,  16'b1010}:        begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'h00; end
        {1'b0, 5'd5,  16'b11100}:       begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'h21; end
        {1'b0, 5'd10, 16'b1111111000}:  begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'hD1; end
        {1'b0, 5'd11, 16'b11111111001}: begin bus.lut_hit = 1'b1; bus.lut_symbol = 8'hF0; end
        default: ;
      endcase
    end
  end

  // Bit source: presents the queue head each cycle, pops it once transferred
  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    forever begin
      @(negedge clock);
      if (took && bit_q.size() > 0) void'(bit_q.pop_front());
      took          = 1'b0;
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      if (bit_q.size() > 0) begin
        if (bit_q[0] == 2) begin
          void'(bit_q.pop_front());
        end else begin
          bus.bit_valid = 1'b1;
          bus.bit_in    = (bit_q[0] == 1);
        end
      end
      #1;
      took = bus.bit_valid && bus.bit_ready && !reset;
    end
  end

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [639:0] put(input logic [639:0] z, input int k, input logic [9:0] v);
    z[639 - 10*k -: 10] = v;
    return z;
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_zz"},     bus.zigzag_pix_out,           640'(0));
    check({pfx, "_code"},   640'(bus.lut_code),           640'(0));
    check({pfx, "_len"},    640'(bus.lut_len),            640'(0));
    check({pfx, "_isdc"},   640'(bus.lut_is_dc),          640'(0));
    check({pfx, "_luma"},   640'(bus.lut_luma),           640'(0));
    check({pfx, "_ready"},  640'(bus.bit_ready),          640'(0));
    check({pfx, "_bv"},     640'(bus.block_valid),        640'(0));
    check({pfx, "_active"}, 640'(bus.Huffmandec_active),  640'(0));
    check({pfx, "_err"},    640'(bus.dec_error),          640'(0));
  endtask

  // Queue a stream; expected latency = stream bits + one lookup cycle per codeword + idle cycles
  task automatic start_block(input bit luma, input string s, input int n_cw,
                             input bit push_exp, input logic [639:0] zz);
    exp_t e;
    int   lat = n_cw;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "0" || s[i] == "1" || s[i] == "s") begin
        bit_q.push_back(s[i] == "s" ? 2 : (s[i] == "1" ? 1 : 0));
        lat++;
      end
    end
    if (push_exp) begin
      e.zz  = zz;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(negedge clock);
    bus.is_luminance      = luma;
    bus.Huffman_dec_start = 1'b1;
    @(negedge clock);
    bus.Huffman_dec_start = 1'b0;
    start_cyc             = cyc;
  endtask

  task automatic watch(input string tag, input int budget, input bit until_err);
    bit   done_flag = 1'b0;
    exp_t e;
    for (int i = 0; i < budget && !done_flag; i++) begin
      @(negedge clock);
      if (bus.block_valid) begin
        bv_cnt++;
        if (exp_q.size() == 0) begin
          check({tag, "_unexp_bv"}, 640'(1), 640'(0));
        end else begin
          e = exp_q.pop_front();
          check({tag, "_zz"},  bus.zigzag_pix_out, e.zz);
          check({tag, "_lat"}, 640'(cyc - start_cyc), 640'(e.lat));
        end
      end
      done_flag = until_err ? bus.dec_error : (exp_q.size() == 0 && !bus.Huffmandec_active);
    end
    if (!done_flag) check({tag, "_timeout"}, 640'(0), 640'(1));
  endtask

  initial begin
    logic [639:0] z;
    int           bv0;
    bus.is_luminance      = 1'b0;
    bus.Huffman_dec_start = 1'b0;
    bus.dc_pred_clear     = 1'b0;
    repeat (3) @(negedge clock);
    check_reset("rst");
    reset = 1'b0;

    // Block 1: DC size 3 value 5, EOB
    start_block(1'b1, "100 101 1010", 2, 1'b1, put('0, 0, 10'd5));
    check("b1_active", 640'(bus.Huffmandec_active), 640'(1));
    check("b1_ready",  640'(bus.bit_ready),         640'(1));
    check("b1_isdc",   640'(bus.lut_is_dc),         640'(1));
    check("b1_luma",   640'(bus.lut_luma),          640'(1));
    watch("b1", 40, 1'b0);

    // Block 2: DC diff -2 on predictor 5
    start_block(1'b1, "011 01 1010", 2, 1'b1, put('0, 0, 10'd3));
    watch("b2", 40, 1'b0);

    // Predictor clear, then DC size 0 on a chroma block
    @(negedge clock);
    bus.dc_pred_clear = 1'b1;
    @(negedge clock);
    bus.dc_pred_clear = 1'b0;
    start_block(1'b0, "00 1010", 2, 1'b1, '0);
    check("b3_luma", 640'(bus.lut_luma), 640'(0));
    watch("b3", 40, 1'b0);

    // AC run 2 size 1 value -1 into coefficient 3, with and without mid-codeword stall
    z = put('0, 3, 10'h3FF);
    start_block(1'b1, "00 11100 0 1010", 3, 1'b1, z);
    watch("b4", 40, 1'b0);
    start_block(1'b1, "00 11sss100 0 1010", 3, 1'b1, z);
    watch("b4s", 40, 1'b0);

    // Fill to coefficient 63 without EOB: DC 7, 3xZRL, run 13 -> coef62=1, coef63=-1
    z = put(put(put('0, 0, 10'd7), 62, 10'd1), 63, 10'h3FF);
    start_block(1'b1, "100 111 11111111001 11111111001 11111111001 1111111000 1 00 0", 6, 1'b1, z);
    watch("b6", 120, 1'b0);

    // Lookup never matches: error after 16 bits, no block_valid
    lut_never = 1'b1;
    bv0       = bv_cnt;
    start_block(1'b0, "11111111111111111111", 0, 1'b0, '0);
    watch("b7", 40, 1'b1);
    check("b7_err",    640'(bus.dec_error),         640'(1));
    check("b7_active", 640'(bus.Huffmandec_active), 640'(0));
    check("b7_nobv",   640'(bv_cnt),                640'(bv0));
    lut_never = 1'b0;
    bit_q.delete();
    repeat (2) @(negedge clock);

    // Next start clears the error; predictor still 7
    start_block(1'b1, "00 1010", 2, 1'b1, put('0, 0, 10'd7));
    check("b8_errclr", 640'(bus.dec_error), 640'(0));
    watch("b8", 40, 1'b0);

    // Four ZRLs from pos 1 overrun the block
    bv0 = bv_cnt;
    start_block(1'b1, "00 11111111001 11111111001 11111111001 11111111001", 0, 1'b0, '0);
    watch("b9", 80, 1'b1);
    check("b9_err",  640'(bus.dec_error), 640'(1));
    check("b9_nobv", 640'(bv_cnt),        640'(bv0));
    repeat (2) @(negedge clock);

    // Reset while waiting in AC_BITS
    start_block(1'b1, "00 11100 ssssssssss", 0, 1'b0, '0);
    repeat (11) @(negedge clock);
    check("b10_active", 640'(bus.Huffmandec_active), 640'(1));
    check("b10_ready",  640'(bus.bit_ready),         640'(1));
    reset = 1'b1;
    bit_q.delete();
    @(negedge clock);
    check_reset("b10");
    reset = 1'b0;

    // Predictor cleared by reset
    start_block(1'b1, "00 1010", 2, 1'b1, '0);
    watch("b11", 40, 1'b0);
    check("b11_sb_empty", 640'(exp_q.size()), 640'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end
endmodule
